// File: rtl/raster_pkg.sv
// Shared constants for the raster counter and the line-buffer blocks that
// consume its coordinates. Defaults describe a 640x480 VGA active window
// inside an 800x525 total raster.
package raster_pkg;

  localparam int H_W_DEF     = 10;
  localparam int V_W_DEF     = 10;
  localparam int FRAME_W_DEF = 8;

  localparam int H_LAST_DEF  = 799;
  localparam int V_LAST_DEF  = 524;

  localparam int WIN_X0_DEF  = 0;
  localparam int WIN_X1_DEF  = 639;
  localparam int WIN_Y0_DEF  = 0;
  localparam int WIN_Y1_DEF  = 479;

  // Inclusive range test, used for the active-window decode.
  function automatic logic in_range(input int v, input int lo, input int hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/raster_counter_if.sv
// Control and position bus of the raster counter.
// win_valid exists only when RASTER_WINDOW_EN is defined.
interface raster_counter_if
  import raster_pkg::*;
#(
  parameter int H_W     = H_W_DEF,
  parameter int V_W     = V_W_DEF,
  parameter int FRAME_W = FRAME_W_DEF
);

  logic               clr;
  logic               enable;
  logic [H_W-1:0]     x_out;
  logic [V_W-1:0]     y_out;
  logic               eol;
  logic               eof;
  logic               frame_done;
  logic [FRAME_W-1:0] frame_cnt;
`ifdef RASTER_WINDOW_EN
  logic               win_valid;

  // Controller side: issues clear/advance, observes position.
  modport master (
    output clr, enable,
    input  x_out, y_out, eol, eof, frame_done, frame_cnt, win_valid
  );

  // Counter side.
  modport slave (
    input  clr, enable,
    output x_out, y_out, eol, eof, frame_done, frame_cnt, win_valid
  );
`else
  modport master (
    output clr, enable,
    input  x_out, y_out, eol, eof, frame_done, frame_cnt
  );

  modport slave (
    input  clr, enable,
    output x_out, y_out, eol, eof, frame_done, frame_cnt
  );
`endif

endinterface

// File: rtl/mod_counter.sv
// Modulo counter: counts 0..LAST on inc, wraps to 0, synchronous clear has
// priority. Any value above LAST (parameter mismatch) is forced to 0 on the
// next increment. tc flags the terminal count.
module mod_counter #(
  parameter int W    = 10,
  parameter int LAST = 799
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         tc
);

  localparam logic [W-1:0] LAST_V = W'(LAST);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear, else wrap-or-increment, else hold.
  always_comb begin
    // NOTE: default assignment first so every path drives cnt_d; no latch.
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = (cnt_q >= LAST_V) ? '0 : cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: non-blocking assignments for all state so parallel registers see old values.
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
  assign tc  = (cnt_q == LAST_V);

endmodule

// File: rtl/raster_counter.sv
// Two-dimensional raster position counter: column x, row y, end-of-line and
// end-of-frame decodes, registered frame_done pulse and wrapping frame count.
// Optional feature macro: RASTER_WINDOW_EN adds a registered win_valid flag
// aligned with x_out/y_out.
module raster_counter
  import raster_pkg::*;
#(
  parameter int H_W     = H_W_DEF,
  parameter int V_W     = V_W_DEF,
  parameter int H_LAST  = H_LAST_DEF,
  parameter int V_LAST  = V_LAST_DEF,
  parameter int FRAME_W = FRAME_W_DEF,
  parameter int WIN_X0  = WIN_X0_DEF,
  parameter int WIN_X1  = WIN_X1_DEF,
  parameter int WIN_Y0  = WIN_Y0_DEF,
  parameter int WIN_Y1  = WIN_Y1_DEF
) (
  input logic              clk,
  input logic              reset_n,
  raster_counter_if.slave  bus
);

  localparam int FRAME_LAST = (1 << FRAME_W) - 1;

  if (longint'(H_LAST) >= (longint'(1) << H_W)) begin : g_h_chk
    $error("raster_counter: H_LAST=%0d does not fit in H_W=%0d bits", H_LAST, H_W);
  end
  if (longint'(V_LAST) >= (longint'(1) << V_W)) begin : g_v_chk
    $error("raster_counter: V_LAST=%0d does not fit in V_W=%0d bits", V_LAST, V_W);
  end
  if ((WIN_X0 > WIN_X1) || (WIN_Y0 > WIN_Y1)) begin : g_win_chk
    $error("raster_counter: empty active window");
  end

  logic [H_W-1:0]     x_cnt;
  logic [V_W-1:0]     y_cnt;
  logic [FRAME_W-1:0] frame_cnt;
  logic               x_tc;
  logic               y_tc;
  logic               eof;
  logic               frame_done_d;
  logic               frame_done_q;

  mod_counter #(.W(H_W), .LAST(H_LAST)) u_x_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (bus.clr),
    .inc     (bus.enable),
    .cnt     (x_cnt),
    .tc      (x_tc)
  );

  mod_counter #(.W(V_W), .LAST(V_LAST)) u_y_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (bus.clr),
    .inc     (bus.enable & x_tc),
    .cnt     (y_cnt),
    .tc      (y_tc)
  );

  // Frame counter wraps naturally at all-ones; its terminal count is not needed.
  mod_counter #(.W(FRAME_W), .LAST(FRAME_LAST)) u_frame_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (bus.clr),
    .inc     (bus.enable & eof),
    .cnt     (frame_cnt),
    .tc      ()
  );

  assign eof          = x_tc & y_tc;
  assign frame_done_d = ~bus.clr & bus.enable & eof;

  // One-cycle pulse following the advance that wraps the frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) frame_done_q <= 1'b0;
    else          frame_done_q <= frame_done_d;
  end

  assign bus.x_out      = x_cnt;
  assign bus.y_out      = y_cnt;
  assign bus.eol        = x_tc;
  assign bus.eof        = eof;
  assign bus.frame_done = frame_done_q;
  assign bus.frame_cnt  = frame_cnt;

`ifdef RASTER_WINDOW_EN
  localparam logic [H_W-1:0] H_LAST_V = H_W'(H_LAST);
  localparam logic [V_W-1:0] V_LAST_V = V_W'(V_LAST);
  localparam logic WIN_RST = in_range(0, WIN_X0, WIN_X1) && in_range(0, WIN_Y0, WIN_Y1);

  logic [H_W-1:0] x_nxt;
  logic [V_W-1:0] y_nxt;
  logic           win_d;
  logic           win_q;

  // Predict the counters' next position so win_valid lands with x_out/y_out.
  always_comb begin
    x_nxt = x_cnt;
    y_nxt = y_cnt;
    if (bus.clr) begin
      x_nxt = '0;
      y_nxt = '0;
    end else if (bus.enable) begin
      x_nxt = (x_cnt >= H_LAST_V) ? '0 : x_cnt + 1'b1;
      if (x_tc) y_nxt = (y_cnt >= V_LAST_V) ? '0 : y_cnt + 1'b1;
    end
    win_d = in_range(int'(x_nxt), WIN_X0, WIN_X1) && in_range(int'(y_nxt), WIN_Y0, WIN_Y1);
  end

  // Window flag register; clear lands on (0,0) and so matches the reset value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) win_q <= WIN_RST;
    else          win_q <= win_d;
  end

  assign bus.win_valid = win_q;
`endif

endmodule

// File: tb/tb_raster_counter.sv
// Self-checking bench for raster_counter on a reduced 20x10 raster.
// Reference model tracks a linear pixel index and a frame count.
module tb_raster_counter;

  localparam int HW   = 5;
  localparam int VW   = 4;
  localparam int FW   = 3;
  localparam int HL   = 19;
  localparam int VL   = 9;
  localparam int WX0  = 3;
  localparam int WX1  = 14;
  localparam int WY0  = 2;
  localparam int WY1  = 6;
  localparam int NX   = HL + 1;
  localparam int NY   = VL + 1;
  localparam int NPIX = NX * NY;
  localparam int NFR  = 1 << FW;
  localparam int AREA = (WX1 - WX0 + 1) * (WY1 - WY0 + 1);
`ifdef RASTER_WINDOW_EN
  localparam int VEC_W = HW + VW + FW + 4;
`else
  localparam int VEC_W = HW + VW + FW + 3;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  // Reference model state.
  int m_p = 0;
  int m_f = 0;
  bit m_fd = 1'b0;

  always #5 clk = ~clk;

  raster_counter_if #(.H_W(HW), .V_W(VW), .FRAME_W(FW)) bus ();

  raster_counter #(
    .H_W(HW), .V_W(VW), .H_LAST(HL), .V_LAST(VL), .FRAME_W(FW),
    .WIN_X0(WX0), .WIN_X1(WX1), .WIN_Y0(WY0), .WIN_Y1(WY1)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  function automatic void model_reset();
    m_p  = 0;
    m_f  = 0;
    m_fd = 1'b0;
  endfunction

  function automatic void model_step(input logic en, input logic cl);
    if (cl) begin
      model_reset();
    end else if (en) begin
      m_fd = (m_p == NPIX - 1);
      m_p  = (m_p + 1) % NPIX;
      if (m_fd) m_f = (m_f + 1) % NFR;
    end else begin
      m_fd = 1'b0;
    end
  endfunction

  function automatic int m_x();
    return m_p % NX;
  endfunction

  function automatic int m_y();
    return m_p / NX;
  endfunction

  function automatic logic [VEC_W-1:0] model_vec();
    logic [HW-1:0] xv;
    logic [VW-1:0] yv;
    logic [FW-1:0] fv;
    logic          eol_e;
    logic          eof_e;
    xv    = HW'(m_x());
    yv    = VW'(m_y());
    fv    = FW'(m_f);
    eol_e = (m_x() == HL);
    eof_e = (m_p == NPIX - 1);
`ifdef RASTER_WINDOW_EN
    return {xv, yv, fv, eol_e, eof_e, m_fd,
            (m_x() >= WX0) && (m_x() <= WX1) && (m_y() >= WY0) && (m_y() <= WY1)};
`else
    return {xv, yv, fv, eol_e, eof_e, m_fd};
`endif
  endfunction

  function automatic logic [VEC_W-1:0] dut_vec();
`ifdef RASTER_WINDOW_EN
    return {bus.x_out, bus.y_out, bus.frame_cnt, bus.eol, bus.eof, bus.frame_done, bus.win_valid};
`else
    return {bus.x_out, bus.y_out, bus.frame_cnt, bus.eol, bus.eof, bus.frame_done};
`endif
  endfunction

  // One clock of stimulus; returns at the following falling edge.
  task automatic drive(input logic en, input logic cl);
    bus.enable = en;
    bus.clr    = cl;
    @(posedge clk);
    model_step(en, cl);
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.enable = 1'b0;
    bus.clr    = 1'b0;
    reset_n    = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    total++;
    if (dut_vec() !== model_vec()) begin
      bad++;
      $display("FAIL reset_state: dut=%h model=%h", dut_vec(), model_vec());
    end
    reset_n = 1'b1;
    drive(1'b0, 1'b0);
    total++;
    if (dut_vec() !== model_vec()) begin
      bad++;
      $display("FAIL reset_hold: dut=%h model=%h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_line();
    for (int i = 0; i < NX; i++) begin
      drive(1'b1, 1'b0);
      total++;
      if (dut_vec() !== model_vec()) begin
        bad++;
        $display("FAIL line[%0d]: dut=%h model=%h", i, dut_vec(), model_vec());
      end
    end
    total++;
    if (bus.x_out !== HW'(0) || bus.y_out !== VW'(1)) begin
      bad++;
      $display("FAIL line_end: x=%0d y=%0d want x=0 y=1", bus.x_out, bus.y_out);
    end
  endtask

  task automatic test_stall_at_eof();
    int guard = 0;
    while (m_p != NPIX - 1 && guard < NPIX + 1) begin
      drive(1'b1, 1'b0);
      guard++;
    end
    total++;
    if (dut_vec() !== model_vec() || m_p != NPIX - 1) begin
      bad++;
      $display("FAIL stall_reach: dut=%h model=%h p=%0d", dut_vec(), model_vec(), m_p);
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0);
      total++;
      if (bus.eol !== 1'b1 || bus.eof !== 1'b1 || bus.frame_done !== 1'b0 ||
          dut_vec() !== model_vec()) begin
        bad++;
        $display("FAIL stall[%0d]: dut=%h model=%h", i, dut_vec(), model_vec());
      end
    end
    drive(1'b1, 1'b0);
    total++;
    if (bus.frame_done !== 1'b1 || bus.x_out !== HW'(0) || bus.y_out !== VW'(0) ||
        dut_vec() !== model_vec()) begin
      bad++;
      $display("FAIL stall_wrap: dut=%h model=%h", dut_vec(), model_vec());
    end
    drive(1'b0, 1'b0);
    total++;
    if (bus.frame_done !== 1'b0 || dut_vec() !== model_vec()) begin
      bad++;
      $display("FAIL stall_pulse_end: dut=%h model=%h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_clr_with_enable();
    int guard = 0;
    while (m_p != 2 * NX + 7 && guard < NPIX + 1) begin
      drive(1'b1, 1'b0);
      guard++;
    end
    total++;
    if (dut_vec() !== model_vec() || bus.frame_cnt === FW'(0)) begin
      bad++;
      $display("FAIL clr_setup: dut=%h model=%h", dut_vec(), model_vec());
    end
    drive(1'b1, 1'b1);
    total++;
    if (bus.x_out !== HW'(0) || bus.y_out !== VW'(0) || bus.frame_cnt !== FW'(0) ||
        bus.frame_done !== 1'b0 || dut_vec() !== model_vec()) begin
      bad++;
      $display("FAIL clr_enable: dut=%h model=%h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_random();
    logic en;
    logic cl;
    for (int i = 0; i < 3000; i++) begin
      en = ($urandom_range(0, 9) < 7);
      cl = ($urandom_range(0, 59) == 0);
      drive(en, cl);
      total++;
      if (dut_vec() !== model_vec()) begin
        bad++;
        $display("FAIL random[%0d] en=%0b clr=%0b: dut=%h model=%h", i, en, cl, dut_vec(), model_vec());
      end
    end
  endtask

  task automatic test_async_reset();
    int guard = 0;
    while (!(m_x() == 8 && m_y() != 0) && guard < NPIX + 1) begin
      drive(1'b1, 1'b0);
      guard++;
    end
    bus.enable = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    total++;
    if (bus.x_out !== HW'(0) || bus.y_out !== VW'(0) || bus.frame_cnt !== FW'(0) ||
        bus.frame_done !== 1'b0 || dut_vec() !== model_vec()) begin
      bad++;
      $display("FAIL async_reset: dut=%h model=%h", dut_vec(), model_vec());
    end
    @(negedge clk);
    reset_n = 1'b1;
    drive(1'b1, 1'b0);
    total++;
    if (bus.x_out !== HW'(1) || dut_vec() !== model_vec()) begin
      bad++;
      $display("FAIL async_first_enable: x=%0d want 1 dut=%h model=%h", bus.x_out, dut_vec(), model_vec());
    end
  endtask

  task automatic test_frame_wrap();
    int pulses = 0;
    int win_cnt [NFR];
    drive(1'b0, 1'b1);
    for (int k = 0; k < NFR; k++) begin
      win_cnt[k] = 0;
      for (int i = 0; i < NPIX; i++) begin
        drive(1'b1, 1'b0);
        total++;
        if (dut_vec() !== model_vec()) begin
          bad++;
          $display("FAIL frame[%0d][%0d]: dut=%h model=%h", k, i, dut_vec(), model_vec());
        end
        if (bus.frame_done === 1'b1) pulses++;
`ifdef RASTER_WINDOW_EN
        if (bus.win_valid === 1'b1) win_cnt[k]++;
`endif
      end
    end
    total++;
    if (pulses != NFR || bus.frame_cnt !== FW'(0)) begin
      bad++;
      $display("FAIL frame_wrap: pulses=%0d want %0d frame_cnt=%0d want 0", pulses, NFR, bus.frame_cnt);
    end
`ifdef RASTER_WINDOW_EN
    for (int k = 0; k < NFR; k++) begin
      total++;
      if (win_cnt[k] != AREA) begin
        bad++;
        $display("FAIL win_count[%0d]: got %0d want %0d", k, win_cnt[k], AREA);
      end
    end
`endif
  endtask

  initial begin
    test_reset();
    test_line();
    test_stall_at_eof();
    test_clr_with_enable();
    test_random();
    test_async_reset();
    test_frame_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
